mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Memory-side responder for the multicycle datapath's memory port.
- The control unit drives Address, MemWr and WriteData.
- This block answers with a fixed-latency read pipeline, so instruction/data words are stable exactly when the control FSM's two wait states end and IRWrite/MDR load.
- Also performs sized writes and flags bad addresses back to the control unit for exception handling.

Parameters:
- DEPTH_WORDS, 64, number of 32-bit words in the array; power of two, 4..1024.
- READ_LAT, 2, cycles from address presentation to ReadData; legal range 1..4.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- Address  input  32  byte address, sampled every cycle.
- MemWr  input  1  write strobe for the current cycle.
- Size  input  2  write size: 0 word, 1 halfword, 2 byte, 3 reserved.
- WriteData  input  32  write data, right-justified (byte in [7:0], half in [15:0]).
- ReadData  output  32  aligned word read READ_LAT cycles earlier.
- ReadValid  output  1  ReadData corresponds to an address sampled after reset release.
- AddrError  output  1  pipelined error flag aligned with ReadData.

Behaviour:
- Reset (async, immediate on assertion):
  - all array words = 0; all pipeline stages cleared.
  - ReadData = 0, ReadValid = 0, AddrError = 0.
  - Reset mid-write drops that write.
- Word index = Address[log2(DEPTH_WORDS)+1:2].
  - Out of range when Address >= 4*DEPTH_WORDS (upper bits nonzero).
- Error detection (combinational on inputs, cycle of issue). Error when any of:
  - out of range;
  - Size=3;
  - MemWr=1 with Size=0 and Address[1:0]!=0;
  - MemWr=1 with Size=1 and Address[0]!=0.
  - Reads (MemWr=0) check range only; Size is ignored for reads.
- Issue (every rising edge, no enable):
  - Stage 1 captures {array word at index, err, valid=1}.
  - Out-of-range or error entries carry data 0.
- Pipeline:
  - Stages 2..READ_LAT shift each cycle.
  - ReadData/ReadValid/AddrError are the last stage's registered outputs.
  - Latency exactly READ_LAT edges: address at edge k appears after edge k+READ_LAT-1.
  - READ_LAT=2 → address held in Start, data stable during WaitMemRead2.
- Writes (same edge as issue, only when MemWr=1 and no error):
  - Little-endian lanes; lane = Address[1:0].
  - Size 0: whole word.
  - Size 1: lanes {A1,0},{A1,1} from WriteData[15:0].
  - Size 2: single lane from WriteData[7:0].
  - Unwritten lanes retain value.
  - Erroneous writes modify nothing; AddrError still reported with latency.
- Read/write collision: a read of a word in the same cycle it is written returns OLD contents (read-before-write). The following cycle's read returns new contents.
- ReadValid:
  - After reset release, ReadValid rises after exactly READ_LAT edges and stays 1 until next reset.
  - No backpressure; no stalls; every cycle produces one response.
- AddrError:
  - Single-cycle per offending request; back-to-back errors give consecutive 1s.
  - No sticky state.

Test Plan:
1. Reset release, Address=0 held: ReadValid=0 after edge 1, 1 after edge 2; ReadData=0, AddrError=0 throughout.
2. Word write then read: MemWr=1, Size=0, Address=0x10, WriteData=0xDEADBEEF for one cycle, then read 0x10. ReadData=0xDEADBEEF exactly 2 edges after the read address. The same-cycle read returned 0x00000000.
3. Byte/half merge, starting from word 0xDEADBEEF at 0x10:
   - Byte write Address=0x13, WriteData=0x000000AA gives 0xAAADBEEF.
   - Half write Address=0x10, WriteData=0x00001234 gives 0xAAAD1234.
4. Misaligned/illegal writes: each produces an AddrError pulse 2 cycles later and leaves the word unchanged.
   - Size=0 at Address=0x12.
   - Size=1 at 0x11.
   - Size=3 at 0x10.
5. Out of range with DEPTH_WORDS=64: read Address=0x100 gives AddrError=1 and ReadData=0 after 2 edges. Write 0x100 does not alias 0x0.
6. Reset mid-pipeline: issue reads of 0x10 and 0x14, assert reset between edges. Outputs go to 0 immediately, the array is cleared, and after release ReadValid stays 0 for 2 edges.

Source files
------------

// File: rtl/mem_responder.sv
// mem_responder: fixed-latency word memory with sized writes and pipelined address-error reporting
module mem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int READ_LAT    = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic        MemWr,
  input  logic [1:0]  Size,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        ReadValid,
  output logic        AddrError
);
  localparam int AW = $clog2(DEPTH_WORDS);
  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] pd [READ_LAT];
  logic [READ_LAT-1:0] pe, pv;
  logic [AW-1:0] idx;
  logic oor, err, we;
  logic [31:0] wmask, wdata;
  // decode index, classify the request and build the lane mask/data for sized writes
  always_comb begin
    idx = Address[AW+1:2];
    oor = |Address[31:AW+2];
    err = oor | (MemWr & ((Size == 2'd3) | ((Size == 2'd0) & |Address[1:0]) | ((Size == 2'd1) & Address[0])));
    we = MemWr & ~err;
    wmask = (Size == 2'd0) ? 32'hFFFF_FFFF :
            (Size == 2'd1) ? 32'h0000_FFFF << {Address[1], 4'b0} :
                             32'h0000_00FF << {Address[1:0], 3'b0};
    wdata = (Size == 2'd0) ? WriteData :
            (Size == 2'd1) ? {2{WriteData[15:0]}} :
                             {4{WriteData[7:0]}};
  end
  // storage: lane-merged write on legal requests; reset clears every word
  always_ff @(posedge clock or posedge reset)
    if (reset)
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
    else if (we)
      mem[idx] <= (mem[idx] & ~wmask) | (wdata & wmask);
  // read pipeline: stage 0 samples old contents (read-before-write), later stages shift
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      for (int i = 0; i < READ_LAT; i++) pd[i] <= '0;
      pe <= '0;
      pv <= '0;
    end else begin
      pd[0] <= err ? '0 : mem[idx];
      pe[0] <= err;
      pv[0] <= 1'b1;
      for (int i = 1; i < READ_LAT; i++) begin
        pd[i] <= pd[i-1];
        pe[i] <= pe[i-1];
        pv[i] <= pv[i-1];
      end
    end
  assign ReadData  = pd[READ_LAT-1];
  assign AddrError = pe[READ_LAT-1];
  assign ReadValid = pv[READ_LAT-1];
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed stimulus with a queued scoreboard checked by an independent monitor
module tb_mem_responder;
  logic        clock, reset, MemWr, ReadValid, AddrError;
  logic [31:0] Address, WriteData, ReadData;
  logic [1:0]  Size;
  typedef struct { logic [31:0] a; logic [31:0] d; logic e; } exp_t;
  exp_t q[$];
  int total = 0, bad = 0;
  mem_responder #(.DEPTH_WORDS(64), .READ_LAT(2)) dut (
    .clock(clock), .reset(reset), .Address(Address), .MemWr(MemWr), .Size(Size),
    .WriteData(WriteData), .ReadData(ReadData), .ReadValid(ReadValid), .AddrError(AddrError)
  );
  initial clock = 1'b0;
  always #5 clock = ~clock;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  // present one request for a full cycle (called just after a falling edge) and queue its response
  task automatic issue(input logic [31:0] a, input logic w, input logic [1:0] s,
                       input logic [31:0] wd, input logic [31:0] ed, input logic ee);
    exp_t x;
    Address = a; MemWr = w; Size = s; WriteData = wd;
    x.a = a; x.d = ed; x.e = ee;
    q.push_back(x);
    @(negedge clock);
  endtask
  // monitor: every valid response is matched against the oldest queued expectation
  initial forever begin
    exp_t x;
    @(negedge clock);
    if (!reset && ReadValid) begin
      if (q.size() == 0) begin
        total++; bad++;
        $display("FAIL resp_unexpected: got data=%0h err=%0b want no response", ReadData, AddrError);
      end else begin
        x = q.pop_front();
        total++;
        if (ReadData !== x.d || AddrError !== x.e) begin
          bad++;
          $display("FAIL resp@%0h: got data=%0h err=%0b want data=%0h err=%0b",
                   x.a, ReadData, AddrError, x.d, x.e);
        end
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    reset = 1'b1; Address = '0; MemWr = 1'b0; Size = '0; WriteData = '0;
    repeat (2) @(negedge clock);
    chk("rst_data", ReadData, 32'h0);
    chk("rst_valid", {31'b0, ReadValid}, 32'h0);
    chk("rst_err", {31'b0, AddrError}, 32'h0);
    reset = 1'b0;
    issue(32'h0, 0, 2'd0, 32'h0, 32'h0, 0);
    chk("valid_edge1", {31'b0, ReadValid}, 32'h0);
    issue(32'h0, 0, 2'd0, 32'h0, 32'h0, 0);
    chk("valid_edge2", {31'b0, ReadValid}, 32'h1);
    issue(32'h10, 1, 2'd0, 32'hDEADBEEF, 32'h0, 0);
    issue(32'h10, 0, 2'd0, 32'h0, 32'hDEADBEEF, 0);
    issue(32'h13, 1, 2'd2, 32'h000000AA, 32'hDEADBEEF, 0);
    issue(32'h10, 0, 2'd0, 32'h0, 32'hAAADBEEF, 0);
    issue(32'h10, 1, 2'd1, 32'h00001234, 32'hAAADBEEF, 0);
    issue(32'h10, 0, 2'd0, 32'h0, 32'hAAAD1234, 0);
    issue(32'h11, 1, 2'd2, 32'hFFFFFF55, 32'hAAAD1234, 0);
    issue(32'h10, 0, 2'd0, 32'h0, 32'hAAAD5534, 0);
    issue(32'h12, 1, 2'd0, 32'hFFFFFFFF, 32'h0, 1);
    issue(32'h11, 1, 2'd1, 32'hFFFFFFFF, 32'h0, 1);
    issue(32'h10, 1, 2'd3, 32'hFFFFFFFF, 32'h0, 1);
    issue(32'h10, 0, 2'd0, 32'h0, 32'hAAAD5534, 0);
    issue(32'h12, 0, 2'd3, 32'h0, 32'hAAAD5534, 0);
    issue(32'h100, 0, 2'd0, 32'h0, 32'h0, 1);
    issue(32'h100, 1, 2'd0, 32'h11111111, 32'h0, 1);
    issue(32'h0, 0, 2'd0, 32'h0, 32'h0, 0);
    issue(32'hFC, 1, 2'd0, 32'hCAFEF00D, 32'h0, 0);
    issue(32'hFC, 0, 2'd0, 32'h0, 32'hCAFEF00D, 0);
    issue(32'h80000010, 0, 2'd0, 32'h0, 32'h0, 1);
    issue(32'h10, 0, 2'd0, 32'h0, 32'hAAAD5534, 0);
    issue(32'h14, 0, 2'd0, 32'h0, 32'h0, 0);
    #1 reset = 1'b1;
    q.delete();
    #1;
    chk("midrst_data", ReadData, 32'h0);
    chk("midrst_valid", {31'b0, ReadValid}, 32'h0);
    chk("midrst_err", {31'b0, AddrError}, 32'h0);
    MemWr = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    issue(32'h10, 0, 2'd0, 32'h0, 32'h0, 0);
    chk("post_valid_edge1", {31'b0, ReadValid}, 32'h0);
    issue(32'hFC, 0, 2'd0, 32'h0, 32'h0, 0);
    chk("post_valid_edge2", {31'b0, ReadValid}, 32'h1);
    @(negedge clock);
    #1;
    chk("queue_drained", q.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
